bin_pack: RTL and testbench

Binarize-and-pack stage for the BNN datapath. It accepts a stream of per-neuron popcount results and compares each against a per-neuron threshold to produce one binary activation. It packs OWIDTH consecutive activations into a bit vector that feeds the next layer's XNOR/popcount input. It is the producing end of the popcount interface: popcount reduces a vector to a count, and bin_pack rebuilds a vector from counts.

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_sign.sv | 14 +
 rtl/bin_pack.sv | 93 +++++++++
 tb/tb_bin_pack.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN datapath stages: sizing helper, FSM state
// encoding and the common pad value used when a vector is flushed early.
package bnn_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } bnn_state_e;

  localparam logic BNN_PAD = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bnn_sign.sv
// Binary activation: fires when the popcount reaches the neuron threshold.
module bnn_sign
  import bnn_pkg::*;
#(
  parameter int CWIDTH = 4
) (
  input  logic [CWIDTH-1:0] cnt_i,
  input  logic [CWIDTH-1:0] thr_i,
  output logic              act_o
);

  assign act_o = (cnt_i >= thr_i);

endmodule

// File: rtl/bin_pack.sv
// Binarize-and-pack stage: thresholds a stream of popcounts and packs the
// resulting activations, LSB first, into vectors for the next layer.
module bin_pack
  import bnn_pkg::*;
#(
  parameter int   OWIDTH = 8,
  parameter int   CWIDTH = 4,
  parameter logic PAD    = BNN_PAD,
  localparam int  NWIDTH = clog2(OWIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] in_cnt,
  input  logic [CWIDTH-1:0] in_thr,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_vec,
  output logic [NWIDTH-1:0] out_nbits
);

  localparam int IWIDTH = (OWIDTH > 1) ? clog2(OWIDTH) : 1;
  localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(OWIDTH - 1);

  bnn_state_e        state_q, state_d;
  logic [IWIDTH-1:0] idx_q, idx_d;
  logic [OWIDTH-1:0] vec_q, vec_d;
  logic [NWIDTH-1:0] nbits_q, nbits_d;
  logic [IWIDTH-1:0] cur_idx;
  logic              act;
  logic              accept;

  bnn_sign #(
    .CWIDTH (CWIDTH)
  ) u_sign (
    .cnt_i (in_cnt),
    .thr_i (in_thr),
    .act_o (act)
  );

  assign in_ready  = !rst && ((state_q == S_FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_FULL);
  assign out_vec   = vec_q;
  assign out_nbits = nbits_q;

  // A consumed vector is replaced by a fresh pad-filled one in the same
  // cycle, so a simultaneous accept lands at bit 0 without a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    nbits_d = nbits_q;
    cur_idx = idx_q;
    if (state_q == S_FULL && out_ready) begin
      state_d = S_FILL;
      vec_d   = {OWIDTH{PAD}};
      idx_d   = '0;
      cur_idx = '0;
    end
    if (accept) begin
      for (int i = 0; i < OWIDTH; i++) begin
        if (cur_idx == IWIDTH'(i)) begin
          vec_d[i] = act;
        end
      end
      if (cur_idx == LAST_IDX || in_last) begin
        state_d = S_FULL;
        nbits_d = NWIDTH'(cur_idx) + NWIDTH'(1);
        idx_d   = '0;
      end else begin
        idx_d = cur_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      vec_q   <= {OWIDTH{PAD}};
      nbits_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      nbits_q <= nbits_d;
    end
  end

endmodule

// File: tb/tb_bin_pack.sv
// Directed bench for bin_pack: OWIDTH=4 instances with PAD=0 and PAD=1 that
// share one stimulus stream, plus an OWIDTH=1 instance.
module tb_bin_pack;

  logic       clk;
  logic       rst;

  logic       a_in_valid;
  logic [3:0] a_in_cnt;
  logic [3:0] a_in_thr;
  logic       a_in_last;
  logic       a_out_ready;
  logic       a_in_ready;
  logic       a_out_valid;
  logic [3:0] a_out_vec;
  logic [2:0] a_out_nbits;

  logic       b_in_ready;
  logic       b_out_valid;
  logic [3:0] b_out_vec;
  logic [2:0] b_out_nbits;

  logic       c_in_valid;
  logic [3:0] c_in_cnt;
  logic [3:0] c_in_thr;
  logic       c_in_last;
  logic       c_out_ready;
  logic       c_in_ready;
  logic       c_out_valid;
  logic [0:0] c_out_vec;
  logic [0:0] c_out_nbits;

  int checks;
  int errors;

  bin_pack #(.OWIDTH(4), .CWIDTH(4), .PAD(1'b0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_cnt    (a_in_cnt),
    .in_thr    (a_in_thr),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_vec   (a_out_vec),
    .out_nbits (a_out_nbits)
  );

  bin_pack #(.OWIDTH(4), .CWIDTH(4), .PAD(1'b1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (b_in_ready),
    .in_cnt    (a_in_cnt),
    .in_thr    (a_in_thr),
    .in_last   (a_in_last),
    .out_valid (b_out_valid),
    .out_ready (a_out_ready),
    .out_vec   (b_out_vec),
    .out_nbits (b_out_nbits)
  );

  bin_pack #(.OWIDTH(1), .CWIDTH(4), .PAD(1'b0)) dut_c (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_cnt    (c_in_cnt),
    .in_thr    (c_in_thr),
    .in_last   (c_in_last),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_vec   (c_out_vec),
    .out_nbits (c_out_nbits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] cnt,
                               input logic [3:0] thr, input logic last);
    a_in_valid = valid;
    a_in_cnt   = cnt;
    a_in_thr   = thr;
    a_in_last  = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] expBits;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    a_out_ready = 1'b1;
    c_out_ready = 1'b1;
    c_in_valid  = 1'b0;
    c_in_cnt    = 4'd0;
    c_in_thr    = 4'd0;
    c_in_last   = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready", {7'd0, a_in_ready}, 8'd0);
    checkOutput("rst_out_valid", {7'd0, a_out_valid}, 8'd0);
    checkOutput("rst_out_vec", {4'd0, a_out_vec}, 8'h0);
    checkOutput("rst_out_nbits", {5'd0, a_out_nbits}, 8'd0);
    checkOutput("rst_out_vec_pad1", {4'd0, b_out_vec}, 8'hF);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {7'd0, a_in_ready}, 8'd1);

    // Basic back-to-back fill: 5,2,7,3 vs 4 -> 0101
    applyStimulus(1'b1, 4'd5, 4'd4, 1'b0);
    tick();
    checkOutput("t1_valid_after1", {7'd0, a_out_valid}, 8'd0);
    applyStimulus(1'b1, 4'd2, 4'd4, 1'b0);
    tick();
    checkOutput("t1_valid_after2", {7'd0, a_out_valid}, 8'd0);
    applyStimulus(1'b1, 4'd7, 4'd4, 1'b0);
    tick();
    checkOutput("t1_valid_after3", {7'd0, a_out_valid}, 8'd0);
    applyStimulus(1'b1, 4'd3, 4'd4, 1'b0);
    tick();
    checkOutput("t1_valid", {7'd0, a_out_valid}, 8'd1);
    checkOutput("t1_vec", {4'd0, a_out_vec}, 8'b0101);
    checkOutput("t1_nbits", {5'd0, a_out_nbits}, 8'd4);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("t1_valid_drop", {7'd0, a_out_valid}, 8'd0);

    // Backpressure: vector 0,5,5,0 vs 3 -> 0110 held for 3 cycles
    a_out_ready = 1'b0;
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd9, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_in_ready_%0d", i), {7'd0, a_in_ready}, 8'd0);
      checkOutput($sformatf("bp_valid_%0d", i), {7'd0, a_out_valid}, 8'd1);
      checkOutput($sformatf("bp_vec_%0d", i), {4'd0, a_out_vec}, 8'b0110);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", {7'd0, a_in_ready}, 8'd1);
    tick();
    checkOutput("bp_after_handshake_valid", {7'd0, a_out_valid}, 8'd0);
    applyStimulus(1'b1, 4'd0, 4'd1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("bp_next_valid", {7'd0, a_out_valid}, 8'd1);
    checkOutput("bp_next_vec", {4'd0, a_out_vec}, 8'b0001);
    checkOutput("bp_next_nbits", {5'd0, a_out_nbits}, 8'd4);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();

    // Early flush after two bits, both pad values
    applyStimulus(1'b1, 4'd6, 4'd4, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd6, 4'd4, 1'b1);
    tick();
    checkOutput("flush_valid", {7'd0, a_out_valid}, 8'd1);
    checkOutput("flush_vec_pad0", {4'd0, a_out_vec}, 8'b0011);
    checkOutput("flush_nbits_pad0", {5'd0, a_out_nbits}, 8'd2);
    checkOutput("flush_vec_pad1", {4'd0, b_out_vec}, 8'b1111);
    checkOutput("flush_nbits_pad1", {5'd0, b_out_nbits}, 8'd2);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();

    // Compare edges: (0,0) (15,15) (14,15) (15,0) -> 1011
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd14, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd0, 1'b0);
    tick();
    checkOutput("edge_valid", {7'd0, a_out_valid}, 8'd1);
    checkOutput("edge_vec", {4'd0, a_out_vec}, 8'b1011);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();

    // Reset mid-vector discards the partial bits
    applyStimulus(1'b1, 4'd15, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_valid", {7'd0, a_out_valid}, 8'd0);
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("midrst_early_valid_%0d", i), {7'd0, a_out_valid}, 8'd0);
    end
    tick();
    checkOutput("midrst_valid_final", {7'd0, a_out_valid}, 8'd1);
    checkOutput("midrst_vec", {4'd0, a_out_vec}, 8'b1111);
    checkOutput("midrst_nbits", {5'd0, a_out_nbits}, 8'd4);

    // Reset while a vector is pending drops it
    a_out_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("fullrst_held", {7'd0, a_out_valid}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("fullrst_valid", {7'd0, a_out_valid}, 8'd0);
    checkOutput("fullrst_vec", {4'd0, a_out_vec}, 8'h0);
    a_out_ready = 1'b1;

    // OWIDTH=1: alternating pass/fail, one output per cycle
    expBits = 8'b01010101;
    c_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_in_cnt = (i % 2 == 0) ? 4'd5 : 4'd2;
      c_in_thr = 4'd4;
      tick();
      checkOutput($sformatf("w1_valid_%0d", i), {7'd0, c_out_valid}, 8'd1);
      checkOutput($sformatf("w1_vec_%0d", i), {7'd0, c_out_vec}, {7'd0, expBits[i]});
      checkOutput($sformatf("w1_nbits_%0d", i), {7'd0, c_out_nbits}, 8'd1);
    end
    c_in_valid = 1'b0;
    tick();
    checkOutput("w1_valid_drop", {7'd0, c_out_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
